// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle controller for the shared 16x16 signed pipelined multiplier
module mul_sequencer #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [15:0] rd_i,
  input  logic [15:0] rs1_i,
  input  logic [15:0] rs2_i,
  input  logic        flush_i,
  input  logic [31:0] mul_p_i,
  output logic [15:0] mul_a_o,
  output logic [15:0] mul_b_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic [15:0] msb_o
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd0, OP_MLA = 2'd1, OP_MLS = 2'd2, OP_MRT = 2'd3;
  localparam logic [2:0] LAT = 3'(MUL_LATENCY);
  logic [1:0]  state_q, state_d, op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rs2_q, rs2_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [15:0] result_q, result_d, msb_q, msb_d;
  logic [31:0] sum;
  assign sum = mul_p_i + {{16{rs2_q[15]}}, rs2_q};
  // Next-state: accept requests in IDLE, count down the pipeline latency, then write back
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rs2_d    = rs2_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    msb_d    = msb_q;
    case (state_q)
      IDLE: if (start_i && !flush_i) begin
        op_d = op_i;
        if (op_i == OP_MRT) begin
          result_d = msb_q;
          state_d  = DONE;
        end else begin
          mul_a_d = op_i == OP_MUL ? rs1_i : rd_i;
          mul_b_d = op_i == OP_MUL ? rs2_i : rs1_i;
          rs2_d   = rs2_i;
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: if (flush_i) state_d = IDLE;
        else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else begin
          state_d  = DONE;
          result_d = op_q == OP_MLS ? rs2_q - mul_p_i[15:0] :
                     op_q == OP_MLA ? sum[15:0] : mul_p_i[15:0];
          msb_d    = op_q == OP_MLS ? msb_q :
                     op_q == OP_MLA ? sum[31:16] : mul_p_i[31:16];
        end
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= 3'd0;
      rs2_q    <= 16'd0;
      mul_a_q  <= 16'd0;
      mul_b_q  <= 16'd0;
      result_q <= 16'd0;
      msb_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rs2_q    <= rs2_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      msb_q    <= msb_d;
    end
  end
  assign mul_a_o  = mul_a_q;
  assign mul_b_o  = mul_b_q;
  assign busy_o   = state_q != IDLE;
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
  assign msb_o    = msb_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer with MUL_LATENCY=2
module tb_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] rd = 16'd0, rs1 = 16'd0, rs2 = 16'd0;
  logic        flush = 1'b0;
  logic [31:0] mul_p = 32'd0;
  logic [15:0] mul_a, mul_b, result, msb;
  logic        busy, done;
  int          n_run = 0, n_fail = 0, n_done;

  mul_sequencer #(.MUL_LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rd_i(rd),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush), .mul_p_i(mul_p),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .busy_o(busy), .done_o(done),
    .result_o(result), .msb_o(msb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start request; returns in cycle 1 of the operation
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    op = o; rd = a; rs1 = b; rs2 = c; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_msb", msb, 0);
    chk("rst_mul_a", mul_a, 0);
    rst_n = 1'b1;
    tick;
    // MUL 300 * -200
    mul_p = 32'hFFFF15A0;
    issue(2'd0, 16'd0, 16'd300, 16'hFF38);
    chk("mul_a_c1", mul_a, 16'h012C);
    chk("mul_b_c1", mul_b, 16'hFF38);
    chk("mul_busy_c1", busy, 1);
    tick; chk("mul_done_c2", done, 0);
    tick; chk("mul_done_c3", done, 0);
    tick;
    chk("mul_done_c4", done, 1);
    chk("mul_result", result, 16'h15A0);
    chk("mul_msb", msb, 16'hFFFF);
    tick;
    chk("mul_idle_c5", busy, 0);
    chk("mul_done_c5", done, 0);
    // MRT returns the multiply MSB register in one cycle
    issue(2'd3, 16'd0, 16'd0, 16'd0);
    chk("mrt_done_c1", done, 1);
    chk("mrt_result", result, 16'hFFFF);
    chk("mrt_msb", msb, 16'hFFFF);
    tick;
    // MLA 1000*1000 + 5
    mul_p = 32'd1000000;
    issue(2'd1, 16'd1000, 16'd1000, 16'd5);
    chk("mla_mul_a", mul_a, 16'h03E8);
    chk("mla_mul_b", mul_b, 16'h03E8);
    tick; tick;
    chk("mla_done_c3", done, 0);
    tick;
    chk("mla_done_c4", done, 1);
    chk("mla_result", result, 16'h4245);
    chk("mla_msb", msb, 16'h000F);
    tick;
    // MLS 10 - 3*4
    mul_p = 32'd12;
    issue(2'd2, 16'd3, 16'd4, 16'd10);
    chk("mls_mul_a", mul_a, 16'h0003);
    chk("mls_mul_b", mul_b, 16'h0004);
    tick; tick; tick;
    chk("mls_done_c4", done, 1);
    chk("mls_result", result, 16'hFFFE);
    chk("mls_msb", msb, 16'h000F);
    tick;
    // Start while busy is ignored
    mul_p = 32'h00020007;
    issue(2'd0, 16'd0, 16'd1, 16'd7);
    tick;
    op = 2'd3; start = 1'b1;
    tick;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      n_done += int'(done);
      tick;
    end
    chk("busy_start_dones", n_done, 1);
    chk("busy_start_result", result, 16'h0007);
    chk("busy_start_msb", msb, 16'h0002);
    chk("busy_start_idle", busy, 0);
    // Flush in WAIT aborts without a done pulse
    mul_p = 32'h12345678;
    issue(2'd0, 16'd0, 16'd5, 16'd6);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy_c3", busy, 0);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      n_done += int'(done);
      tick;
    end
    chk("flush_dones", n_done, 0);
    chk("flush_msb", msb, 16'h0002);
    chk("flush_result", result, 16'h0007);
    // Flush and start together in IDLE: flush wins
    op = 2'd3; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);
    chk("flush_start_done", done, 0);
    // Reset mid-operation clears everything at once
    issue(2'd0, 16'd0, 16'd9, 16'd9);
    tick;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mul_a", mul_a, 0);
    chk("arst_result", result, 0);
    chk("arst_msb", msb, 0);
    tick;
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_done += int'(done);
    end
    chk("arst_no_done", n_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
